// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS core: next-PC source encodings,
// the reset fetch address and the nop instruction word.
package cpu_defs;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_BR  = 2'd1,
    NPC_J   = 2'd2,
    NPC_JR  = 2'd3
  } npc_sel_e;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_stage_npc.sv
// Combinational next-PC calculator. Branch and jump targets are formed
// from the instruction sitting in D, never from the fetch PC.
module npc
  import cpu_defs::*;
(
  input  logic [31:0] pc_f,
  input  logic [31:0] pc_d,
  input  logic [31:0] instr_d,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  function automatic logic signed [31:0] sext16(input logic [15:0] imm);
    sext16 = {{16{imm[15]}}, imm};
  endfunction

  logic        [31:0] seq_pc;
  logic signed [31:0] br_offset;
  logic        [31:0] br_target;
  logic        [31:0] j_target;

  assign seq_pc    = pc_f + 32'd4;
  assign br_offset = sext16(instr_d[15:0]) <<< 2;
  assign br_target = pc_d + 32'd4 + $unsigned(br_offset);
  assign j_target  = {pc_d[31:28], instr_d[25:0], 2'b00};

  // Select the next fetch address; an untaken branch falls through to seq.
  always_comb begin
    next_pc = seq_pc;
    case (npc_sel_e'(npc_sel))
      NPC_SEQ: next_pc = seq_pc;
      NPC_BR:  next_pc = br_taken ? br_target : seq_pc;
      NPC_J:   next_pc = j_target;
      NPC_JR:  next_pc = jr_target;
      default: next_pc = seq_pc;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC register plus the IF/ID pipeline
// register. The delay-slot word is never flushed.
module if_stage #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] jr_target,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D
);
  import cpu_defs::*;

  logic [31:0] pc_f;
  logic [31:0] instr_d_q;
  logic [31:0] pc_d_q;
  logic [31:0] next_pc;

  npc u_npc (
    .pc_f      (pc_f),
    .pc_d      (pc_d_q),
    .instr_d   (instr_d_q),
    .npc_sel   (npc_sel),
    .br_taken  (br_taken),
    .jr_target (jr_target),
    .next_pc   (next_pc)
  );

  // F -> D boundary: advance PC and latch fetched word unless stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f      <= RESET_PC;
      instr_d_q <= NOP_WORD;
      pc_d_q    <= '0;
    end else if (!stall) begin
      pc_f      <= next_pc;
      instr_d_q <= im_rdata;
      pc_d_q    <= pc_f;
    end
  end

  assign im_addr = pc_f;
  assign instr_D = instr_d_q;
  assign pc_D    = pc_d_q;
  assign pc8_D   = pc_d_q + 32'd8;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a small instruction memory feeds the
// DUT, expected (im_addr, instr_D, pc_D) tuples are queued with each
// stimulus step and compared after the clock edge.
module tb_if_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'd0;
  logic        br_taken = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [31:0] mem [0:127];

  if_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .npc_sel   (npc_sel),
    .br_taken  (br_taken),
    .jr_target (jr_target),
    .im_addr   (im_addr),
    .im_rdata  (im_rdata),
    .instr_D   (instr_D),
    .pc_D      (pc_D),
    .pc8_D     (pc8_D)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a >= 32'h3000 && a < 32'h3200) word_at = mem[(a - 32'h3000) >> 2];
    else                               word_at = {a[15:0], ~a[15:0]};
  endfunction

  assign im_rdata = word_at(im_addr);

  // Apply one cycle of stimulus and sample 1 time unit after the edge.
  task automatic step(input logic r, input logic s, input logic [1:0] sel,
                      input logic bt, input logic [31:0] jt);
    reset = r; stall = s; npc_sel = sel; br_taken = bt; jr_target = jt;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    e.addr = a; e.instr = i; e.pc = p;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      push(32'h3000, 32'h0, 32'h0);
      step(1'b1, (k < 2), 2'd2, 1'b1, 32'h1234);
      e = sb.pop_front();
      checks++;
      if (im_addr !== e.addr || instr_D !== e.instr || pc_D !== e.pc) begin
        errors++;
        $display("FAIL reset[%0d] got addr=%h instr=%h pc=%h want addr=%h instr=%h pc=%h",
                 k, im_addr, instr_D, pc_D, e.addr, e.instr, e.pc);
      end
    end
  endtask

  task automatic test_seq();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      push(32'h3004 + 4*k, mem[k], 32'h3000 + 4*k);
      step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
      e = sb.pop_front();
      checks++;
      if (im_addr !== e.addr || instr_D !== e.instr || pc_D !== e.pc) begin
        errors++;
        $display("FAIL seq[%0d] got addr=%h instr=%h pc=%h want addr=%h instr=%h pc=%h",
                 k, im_addr, instr_D, pc_D, e.addr, e.instr, e.pc);
      end
      checks++;
      if (pc8_D !== e.pc + 32'd8) begin
        errors++;
        $display("FAIL seq_pc8[%0d] got %h want %h", k, pc8_D, e.pc + 32'd8);
      end
    end
  endtask

  task automatic test_branch();
    logic [1:0]  sel [4];
    logic        bt  [4];
    logic [31:0] jt  [4];
    exp_t e;
    // State entering: PC_F=300C, pc_D=3008.
    sel = '{2'd3, 2'd0, 2'd1, 2'd1};
    bt  = '{1'b0, 1'b0, 1'b1, 1'b0};
    jt  = '{32'h3004, 32'h0, 32'h0, 32'h0};
    push(32'h3004, mem[3], 32'h300C);
    push(32'h3008, mem[1], 32'h3004);   // branch with imm16=FFFF now in D
    push(32'h3004, mem[2], 32'h3008);   // taken: back to 3004, delay slot in D
    push(32'h3008, mem[1], 32'h3004);   // npc_sel=1 untaken: PC_F+4
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, sel[k], bt[k], jt[k]);
      e = sb.pop_front();
      checks++;
      if (im_addr !== e.addr || instr_D !== e.instr || pc_D !== e.pc) begin
        errors++;
        $display("FAIL branch[%0d] got addr=%h instr=%h pc=%h want addr=%h instr=%h pc=%h",
                 k, im_addr, instr_D, pc_D, e.addr, e.instr, e.pc);
      end
    end
  endtask

  task automatic test_jump();
    logic [1:0]  sel [5];
    logic [31:0] jt  [5];
    exp_t e;
    // State entering: PC_F=3008, pc_D=3004.
    sel = '{2'd3, 2'd0, 2'd2, 2'd3, 2'd3};
    jt  = '{32'h3010, 32'h0, 32'h0, 32'h3100, 32'h3003};
    push(32'h3010, mem[2], 32'h3008);
    push(32'h3014, mem[4], 32'h3010);   // j with target field 0xC10 in D
    push(32'h3040, mem[5], 32'h3014);   // j_target
    push(32'h3100, mem[16], 32'h3040);  // jr
    push(32'h3003, mem[64], 32'h3100);  // jr low bits pass through
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, sel[k], 1'b1, jt[k]);
      e = sb.pop_front();
      checks++;
      if (im_addr !== e.addr || instr_D !== e.instr || pc_D !== e.pc) begin
        errors++;
        $display("FAIL jump[%0d] got addr=%h instr=%h pc=%h want addr=%h instr=%h pc=%h",
                 k, im_addr, instr_D, pc_D, e.addr, e.instr, e.pc);
      end
    end
  endtask

  task automatic test_stall();
    logic [1:0]  sel [5];
    logic        st  [5];
    logic [31:0] jt  [5];
    exp_t e;
    // State entering: PC_F=3003, pc_D=3100.
    sel = '{2'd3, 2'd0, 2'd2, 2'd2, 2'd2};
    st  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    jt  = '{32'h3010, 32'h0, 32'h0, 32'h0, 32'h0};
    push(32'h3010, mem[0], 32'h3003);   // word at 0x3003 maps to mem[0]
    push(32'h3014, mem[4], 32'h3010);
    push(32'h3014, mem[4], 32'h3010);   // stalled
    push(32'h3014, mem[4], 32'h3010);   // stalled
    push(32'h3040, mem[5], 32'h3014);   // jump taken on first free edge
    for (int k = 0; k < 5; k++) begin
      step(1'b0, st[k], sel[k], 1'b1, jt[k]);
      e = sb.pop_front();
      checks++;
      if (im_addr !== e.addr || instr_D !== e.instr || pc_D !== e.pc) begin
        errors++;
        $display("FAIL stall[%0d] got addr=%h instr=%h pc=%h want addr=%h instr=%h pc=%h",
                 k, im_addr, instr_D, pc_D, e.addr, e.instr, e.pc);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    // State entering: PC_F=3040, pc_D=3014.
    push(32'hFFFF_FFFC, mem[16], 32'h3040);
    step(1'b0, 1'b0, 2'd3, 1'b0, 32'hFFFF_FFFC);
    e = sb.pop_front();
    checks++;
    if (im_addr !== e.addr || instr_D !== e.instr || pc_D !== e.pc) begin
      errors++;
      $display("FAIL wrap_jr got addr=%h instr=%h pc=%h want addr=%h instr=%h pc=%h",
               im_addr, instr_D, pc_D, e.addr, e.instr, e.pc);
    end
    push(32'h0000_0000, 32'hFFFC_0003, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
    e = sb.pop_front();
    checks++;
    if (im_addr !== e.addr || instr_D !== e.instr || pc_D !== e.pc) begin
      errors++;
      $display("FAIL wrap_seq got addr=%h instr=%h pc=%h want addr=%h instr=%h pc=%h",
               im_addr, instr_D, pc_D, e.addr, e.instr, e.pc);
    end
    checks++;
    if (pc8_D !== 32'h0000_0004) begin
      errors++;
      $display("FAIL wrap_pc8 got %h want %h", pc8_D, 32'h0000_0004);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h2400_0000 | (i << 4) | 32'h3;
    mem[1] = 32'h1000_FFFF;   // branch, imm16 = -1
    mem[4] = 32'h0800_0C10;   // j, target field 0x0000C10
    #1;
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
